// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, parity-mode encodings
// and a helper giving the frame length in bit times.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // The reserved encoding 2'b11 sends no parity bit, same as PAR_NONE.
   function automatic logic parity_active(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   function automatic int unsigned frame_bit_times(input int unsigned data_bits,
                                                   input logic        parity_en,
                                                   input logic        two_stop);
      int unsigned n;
      n = 32'd1 + data_bits + 32'd1;
      if (parity_en) n = n + 32'd1;
      if (two_stop)  n = n + 32'd1;
      return n;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// Full/empty flags are registered and update on the edge after a push or pop.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [AW:0]      count_next;
   logic             full_reg;
   logic             empty_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full_reg;
   assign do_pop  = pop && !empty_reg;

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_DEPTH);
         empty_reg <= (count_next == '0);
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= push_data;
   end

   assign pop_data = mem_reg[rd_ptr_reg];
   assign full     = full_reg;
   assign empty    = empty_reg;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: bit-rate divider, parity generator and framing FSM with a
// transmit buffer. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_enable,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic [1:0]           parity_mode,
   input  logic                 stop_bits,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic                 overflow
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   logic                 src_pop;
   logic [DATA_BITS-1:0] src_data;
   logic                 src_full;
   logic                 src_empty;
   logic                 push;

   assign push = wr_enable && !src_full;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (tx_data),
      .pop       (src_pop),
      .pop_data  (src_data),
      .full      (src_full),
      .empty     (src_empty)
   );
`else
   logic                 hold_valid_reg;
   logic [DATA_BITS-1:0] hold_data_reg;
   logic                 unused_fifo_depth;

   // FIFO_DEPTH has no meaning without the FIFO.
   assign unused_fifo_depth = (FIFO_DEPTH != 0);

   // Push needs an empty register and pop a full one, so they never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_reg <= 1'b0;
         hold_data_reg  <= '0;
      end else if (push) begin
         hold_valid_reg <= 1'b1;
         hold_data_reg  <= tx_data;
      end else if (src_pop) begin
         hold_valid_reg <= 1'b0;
      end
   end

   assign src_full  = hold_valid_reg;
   assign src_empty = !hold_valid_reg;
   assign src_data  = hold_data_reg;
`endif

   tx_state_e            state_reg, state_next;
   logic [DIV_W-1:0]     div_reg, div_next;
   logic [BIT_W-1:0]     bit_idx_reg, bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_en_reg, par_en_next;
   logic                 par_bit_reg, par_bit_next;
   logic                 stop2_reg, stop2_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic                 tx_out_reg, tx_out_next;
   logic                 busy_reg, busy_next;
   logic                 overflow_reg;
   logic                 div_tc;
   logic                 load_frame;

   assign div_tc = (div_reg == DIV_LAST);

   // tx_out_next is the line level of the bit the FSM is entering, so the
   // registered output lines up with the state change.
   always_comb begin
      state_next    = state_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      par_en_next   = par_en_reg;
      par_bit_next  = par_bit_reg;
      stop2_next    = stop2_reg;
      stop_cnt_next = stop_cnt_reg;
      tx_out_next   = tx_out_reg;
      busy_next     = busy_reg;
      load_frame    = 1'b0;
      src_pop       = 1'b0;
      div_next      = (state_reg == IDLE || div_tc) ? '0 : div_reg + DIV_ONE;

      case (state_reg)
         IDLE: begin
            if (!src_empty) load_frame = 1'b1;
         end
         START: begin
            if (div_tc) begin
               state_next   = DATA;
               bit_idx_next = '0;
               tx_out_next  = shift_reg[0];
            end
         end
         DATA: begin
            if (div_tc) begin
               if (bit_idx_reg == BIT_LAST) begin
                  if (par_en_reg) begin
                     state_next  = PARITY;
                     tx_out_next = par_bit_reg;
                  end else begin
                     state_next    = STOP;
                     stop_cnt_next = 1'b0;
                     tx_out_next   = 1'b1;
                  end
               end else begin
                  shift_next   = shift_reg >> 1;
                  bit_idx_next = bit_idx_reg + BIT_ONE;
                  tx_out_next  = shift_reg[1];
               end
            end
         end
         PARITY: begin
            if (div_tc) begin
               state_next    = STOP;
               stop_cnt_next = 1'b0;
               tx_out_next   = 1'b1;
            end
         end
         STOP: begin
            if (div_tc) begin
               if (stop2_reg && !stop_cnt_reg) begin
                  stop_cnt_next = 1'b1;
               end else if (!src_empty) begin
                  load_frame = 1'b1;
               end else begin
                  state_next  = IDLE;
                  busy_next   = 1'b0;
                  tx_out_next = 1'b1;
               end
            end
         end
         default: begin
            state_next  = IDLE;
            busy_next   = 1'b0;
            tx_out_next = 1'b1;
         end
      endcase

      // Frame settings are captured with the data so mid-frame changes wait.
      if (load_frame) begin
         src_pop      = 1'b1;
         state_next   = START;
         shift_next   = src_data;
         par_en_next  = parity_active(parity_mode);
         par_bit_next = (^src_data) ^ (parity_mode == PAR_ODD);
         stop2_next   = stop_bits;
         tx_out_next  = 1'b0;
         busy_next    = 1'b1;
         div_next     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         div_reg      <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         par_en_reg   <= 1'b0;
         par_bit_reg  <= 1'b0;
         stop2_reg    <= 1'b0;
         stop_cnt_reg <= 1'b0;
         tx_out_reg   <= 1'b1;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         div_reg      <= div_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
         par_en_reg   <= par_en_next;
         par_bit_reg  <= par_bit_next;
         stop2_reg    <= stop2_next;
         stop_cnt_reg <= stop_cnt_next;
         tx_out_reg   <= tx_out_next;
         busy_reg     <= busy_next;
         overflow_reg <= wr_enable && src_full;
      end
   end

   assign tx_out     = tx_out_reg;
   assign tx_busy    = busy_reg;
   assign fifo_full  = src_full;
   assign fifo_empty = src_empty;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: a scoreboard of expected frames is
// checked bit by bit against the serial line by an independent monitor.
`timescale 1ns/1ps
module tb_uart_tx_core;

   localparam int DATA_BITS  = 8;
   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_FIFO_EN
   localparam bit FIFO_MODE = 1'b1;
`else
   localparam bit FIFO_MODE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       wr_enable = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [1:0] parity_mode = 2'b00;
   logic       stop_bits = 1'b0;
   logic       tx_out, tx_busy, fifo_full, fifo_empty, overflow;

   uart_tx_core #(
      .DATA_BITS  (DATA_BITS),
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_enable   (wr_enable),
      .tx_data     (tx_data),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .tx_out      (tx_out),
      .tx_busy     (tx_busy),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] pmode;
      logic       stop2;
   } exp_t;

   exp_t sb_q[$];
   int   runs_q[$];
   int   checks = 0;
   int   failures = 0;
   int   frames_done = 0;
   int   busy_run = 0;
   bit   mon_active = 1'b0;
   logic exp_bits [0:12];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   // Length of every contiguous tx_busy run, in cycles.
   always @(negedge clk) begin
      if (!rst_n) busy_run <= 0;
      else if (tx_busy) busy_run <= busy_run + 1;
      else if (busy_run != 0) begin
         runs_q.push_back(busy_run);
         busy_run <= 0;
      end
   end

   initial begin : monitor
      exp_t e;
      int   nbits;
      bit   aborted;
      forever begin
         @(negedge clk);
         if (rst_n && tx_out === 1'b0) begin
            if (sb_q.size() == 0) begin
               fail_now("unexpected_start");
               for (int k = 0; k < 200; k++) begin
                  if (tx_out === 1'b1) break;
                  @(negedge clk);
               end
            end else begin
               mon_active = 1'b1;
               e = sb_q.pop_front();
               exp_bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) exp_bits[1 + i] = e.data[i];
               nbits = 9;
               if (e.pmode == 2'b01) begin
                  exp_bits[nbits] = ^e.data;
                  nbits++;
               end else if (e.pmode == 2'b10) begin
                  exp_bits[nbits] = ~(^e.data);
                  nbits++;
               end
               exp_bits[nbits] = 1'b1;
               nbits++;
               if (e.stop2) begin
                  exp_bits[nbits] = 1'b1;
                  nbits++;
               end
               aborted = 1'b0;
               for (int c = 0; c < nbits * CLK_DIV; c++) begin
                  if (c > 0) @(negedge clk);
                  if (!rst_n) begin
                     aborted = 1'b1;
                     break;
                  end
                  check($sformatf("frame%0d_data%02h_bit%0d", frames_done, e.data, c / CLK_DIV),
                        {31'd0, tx_out}, {31'd0, exp_bits[c / CLK_DIV]});
               end
               if (!aborted) frames_done++;
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle(input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         @(negedge clk);
         if (!tx_busy && fifo_empty && sb_q.size() == 0 && !mon_active) break;
      end
      if (k == limit) fail_now("idle_timeout");
      repeat (2) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] d, input logic [1:0] pm, input logic s2);
      exp_t e;
      for (int k = 0; k < 2000 && fifo_full; k++) @(negedge clk);
      if (fifo_full) fail_now("write_wait");
      e.data  = d;
      e.pmode = pm;
      e.stop2 = s2;
      tx_data   = d;
      wr_enable = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      wr_enable = 1'b0;
   endtask

   task automatic check_single_run(input string tag, input int exp_len);
      check({tag, "_runs"}, runs_q.size(), 1);
      if (runs_q.size() > 0) check(tag, runs_q[0], exp_len);
   endtask

   initial begin : stimulus
      logic [5:0] acc, exp_ovf, exp_full, ovf_s, full_s;
      int         frames0, bad_cycles;

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx_out", tx_out, 1);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_fifo_full", fifo_full, 0);
      check("rst_fifo_empty", fifo_empty, 1);
      check("rst_overflow", overflow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_tx_out", tx_out, 1);
      check("post_rst_empty", fifo_empty, 1);

      // Even parity, one stop bit, 0xD8: 44 busy cycles
      parity_mode = 2'b01;
      stop_bits   = 1'b0;
      runs_q.delete();
      write_byte(8'hD8, 2'b01, 1'b0);
      check("e0_busy", tx_busy, 0);
      check("e0_empty", fifo_empty, 0);
      @(negedge clk);
      check("e1_busy", tx_busy, 1);
      check("e1_tx_out", tx_out, 0);
      check("e1_empty", fifo_empty, 1);
      wait_idle(500);
      check_single_run("even_busy_len", 44);

      // Odd parity, two stop bits: 48 busy cycles
      parity_mode = 2'b10;
      stop_bits   = 1'b1;
      runs_q.delete();
      write_byte(8'hD8, 2'b10, 1'b1);
      wait_idle(500);
      check_single_run("odd_busy_len", 48);

      // Three back-to-back frames, no parity, one stop: 120 contiguous busy cycles
      parity_mode = 2'b00;
      stop_bits   = 1'b0;
      runs_q.delete();
      write_byte(8'h01, 2'b00, 1'b0);
      write_byte(8'h02, 2'b00, 1'b0);
      write_byte(8'h03, 2'b00, 1'b0);
      wait_idle(1000);
      check_single_run("b2b_busy_len", 120);

      // Six writes on consecutive cycles regardless of fifo_full
      parity_mode = 2'b01;
      stop_bits   = 1'b1;
      acc      = FIFO_MODE ? 6'b011111 : 6'b000101;
      exp_ovf  = FIFO_MODE ? 6'b100000 : 6'b111010;
      exp_full = FIFO_MODE ? 6'b110000 : 6'b111101;
      frames0  = frames_done;
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         tx_data   = 8'hA0 + 8'(i);
         wr_enable = 1'b1;
         if (acc[i]) begin
            e.data  = tx_data;
            e.pmode = 2'b01;
            e.stop2 = 1'b1;
            sb_q.push_back(e);
         end
         @(negedge clk);
         ovf_s[i]  = overflow;
         full_s[i] = fifo_full;
      end
      wr_enable = 1'b0;
      @(negedge clk);
      check("burst_ovf_after", overflow, 0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("burst_ovf_w%0d", i), ovf_s[i], exp_ovf[i]);
         check($sformatf("burst_full_w%0d", i), full_s[i], exp_full[i]);
      end
      wait_idle(2000);
      check("burst_frames", frames_done - frames0, FIFO_MODE ? 5 : 2);

      // parity_mode changed mid-frame: only the following frame gets parity
      parity_mode = 2'b00;
      stop_bits   = 1'b0;
      runs_q.delete();
      write_byte(8'hA7, 2'b00, 1'b0);
      write_byte(8'h35, 2'b10, 1'b0);
      repeat (8) @(negedge clk);
      parity_mode = 2'b10;
      wait_idle(1000);
      check_single_run("midchange_busy_len", 84);

      // Reserved parity encoding sends no parity bit
      parity_mode = 2'b11;
      runs_q.delete();
      write_byte(8'h3C, 2'b11, 1'b0);
      wait_idle(500);
      check_single_run("reserved_busy_len", 40);

      // Reset during the third data bit, with a second byte pending
      parity_mode = 2'b00;
      stop_bits   = 1'b0;
      write_byte(8'h5A, 2'b00, 1'b0);
      write_byte(8'hC3, 2'b00, 1'b0);
      for (int k = 0; k < 200; k++) begin
         if (tx_busy && busy_run == 13) break;
         @(negedge clk);
      end
      check("pre_rst_busy_cycle", busy_run, 13);
      check("pre_rst_data_bit2", tx_out, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx_out", tx_out, 1);
      check("midrst_tx_busy", tx_busy, 0);
      check("midrst_fifo_empty", fifo_empty, 1);
      check("midrst_fifo_full", fifo_full, 0);
      sb_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad_cycles = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b1) bad_cycles++;
      end
      check("postrst_idle_bad_cycles", bad_cycles, 0);

      wait_idle(500);
      check("final_scoreboard_left", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
